// File: rtl/si5340_load_sequencer.sv
// si5340_load_sequencer
// Upstream control stage for the Si5340 configuration loader. It issues one
// load strobe per memory entry. It waits for the loader to finish each
// transaction and spaces the entries with an idle gap. It inserts the long
// settle delay after the preamble entries of the write pass. It can repeat
// the whole image as a read-back pass. If the loader never answers, it
// reports a sticky timeout error.
//
// Output timing: load_o rises one cycle after the FSM enters ISSUE, which is
// the first cycle of WAIT_DONE. Every other output is registered in the
// same edge that enters the state it belongs to.
//
// NUM_ENTRIES must be at least 2, because entry_idx_o is $clog2(NUM_ENTRIES)
// bits wide. DELAY_CYCLES and GAP_CYCLES must be at least 1.

module si5340_load_sequencer #(
    parameter int NUM_ENTRIES    = 512,
    parameter int PREAMBLE_LEN   = 3,
    parameter int DELAY_CYCLES   = 30_000_000,
    parameter int GAP_CYCLES     = 4,
    parameter int TIMEOUT_CYCLES = 1_000_000,
    parameter int READBACK       = 1
) (
    input  logic                           clk_i,
    input  logic                           arstn_i,
    input  logic                           start_i,
    input  logic                           loader_done_i,
    output logic                           load_o,
    output logic                           write_o,
    output logic                           busy_o,
    output logic                           done_o,
    output logic                           timeout_err_o,
    output logic [$clog2(NUM_ENTRIES)-1:0] entry_idx_o
);

    localparam int IDX_W    = $clog2(NUM_ENTRIES);
    localparam int TMO_W    = $clog2(TIMEOUT_CYCLES) + 1;
    localparam int WAIT_MAX = (DELAY_CYCLES > GAP_CYCLES) ? DELAY_CYCLES : GAP_CYCLES;
    localparam int WAIT_W   = $clog2(WAIT_MAX) + 1;

    localparam bit               HAS_PRE     = (PREAMBLE_LEN > 0);
    localparam bit               READBACK_EN = (READBACK != 0);
    localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(NUM_ENTRIES - 1);
    localparam logic [IDX_W-1:0] PRE_IDX     = IDX_W'((PREAMBLE_LEN > 0) ? (PREAMBLE_LEN - 1) : 0);
    localparam logic [TMO_W-1:0] TMO_LAST    = TMO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [WAIT_W-1:0] DLY_LAST   = WAIT_W'(DELAY_CYCLES - 1);
    localparam logic [WAIT_W-1:0] GAP_LAST   = WAIT_W'(GAP_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ISSUE     = 3'd1,
        ST_WAIT_DONE = 3'd2,
        ST_GAP       = 3'd3,
        ST_DELAY     = 3'd4,
        ST_NEXT      = 3'd5,
        ST_FINISH    = 3'd6,
        ST_ERROR     = 3'd7
    } state_t;

    state_t            state_r;
    logic [IDX_W-1:0]  entry_idx_r;
    logic [TMO_W-1:0]  tmo_cnt_r;
    logic [WAIT_W-1:0] wait_cnt_r;
    logic              load_r;
    logic              write_r;
    logic              busy_r;
    logic              done_r;
    logic              timeout_err_r;

    logic tmo_last_s;
    logic dly_last_s;
    logic gap_last_s;
    logic delay_entry_s;
    logic last_entry_s;
    logic next_pass_s;

    // Terminal counts and routing decisions that the state machine uses.
    always_comb begin
        tmo_last_s    = (tmo_cnt_r == TMO_LAST);
        dly_last_s    = (wait_cnt_r == DLY_LAST);
        gap_last_s    = (wait_cnt_r == GAP_LAST);
        delay_entry_s = HAS_PRE && write_r && (entry_idx_r == PRE_IDX);
        last_entry_s  = (entry_idx_r == LAST_IDX);
        next_pass_s   = READBACK_EN && write_r;
    end

    // Sequencer state machine with all outputs registered.
    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            state_r       <= ST_IDLE;
            entry_idx_r   <= '0;
            tmo_cnt_r     <= '0;
            wait_cnt_r    <= '0;
            load_r        <= 1'b0;
            write_r       <= 1'b0;
            busy_r        <= 1'b0;
            done_r        <= 1'b0;
            timeout_err_r <= 1'b0;
        end else begin
            // Strobes default low so that each one lasts exactly one cycle.
            load_r <= 1'b0;
            done_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (start_i) begin
                        state_r       <= ST_ISSUE;
                        entry_idx_r   <= '0;
                        write_r       <= 1'b1;
                        busy_r        <= 1'b1;
                        timeout_err_r <= 1'b0;
                    end
                end
                ST_ISSUE: begin
                    load_r    <= 1'b1;
                    tmo_cnt_r <= '0;
                    state_r   <= ST_WAIT_DONE;
                end
                ST_WAIT_DONE: begin
                    // A done pulse takes priority over a timeout that
                    // expires in the same cycle.
                    if (loader_done_i) begin
                        wait_cnt_r <= '0;
                        if (delay_entry_s) begin
                            state_r <= ST_DELAY;
                        end else begin
                            state_r <= ST_GAP;
                        end
                    end else if (tmo_last_s) begin
                        state_r       <= ST_ERROR;
                        timeout_err_r <= 1'b1;
                        busy_r        <= 1'b0;
                    end else begin
                        tmo_cnt_r <= tmo_cnt_r + TMO_W'(1);
                    end
                end
                ST_DELAY: begin
                    if (dly_last_s) begin
                        state_r <= ST_NEXT;
                    end else begin
                        wait_cnt_r <= wait_cnt_r + WAIT_W'(1);
                    end
                end
                ST_GAP: begin
                    if (gap_last_s) begin
                        state_r <= ST_NEXT;
                    end else begin
                        wait_cnt_r <= wait_cnt_r + WAIT_W'(1);
                    end
                end
                ST_NEXT: begin
                    if (!last_entry_s) begin
                        entry_idx_r <= entry_idx_r + IDX_W'(1);
                        state_r     <= ST_ISSUE;
                    end else if (next_pass_s) begin
                        // The read pass follows at once. The loader's own
                        // index has already wrapped to entry 0.
                        entry_idx_r <= '0;
                        write_r     <= 1'b0;
                        state_r     <= ST_ISSUE;
                    end else begin
                        state_r <= ST_FINISH;
                        done_r  <= 1'b1;
                        busy_r  <= 1'b0;
                    end
                end
                ST_FINISH: begin
                    state_r <= ST_IDLE;
                end
                ST_ERROR: begin
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign load_o        = load_r;
    assign write_o       = write_r;
    assign busy_o        = busy_r;
    assign done_o        = done_r;
    assign timeout_err_o = timeout_err_r;
    assign entry_idx_o   = entry_idx_r;

endmodule

// File: tb/tb_si5340_load_sequencer.sv
// Directed testbench for si5340_load_sequencer. It uses a small loader model
// and an expected-load scoreboard. There are two instances: u_dut runs with
// read-back enabled and u_dut_nr runs with read-back disabled.

module tb_si5340_load_sequencer;

    localparam int N_C   = 4;
    localparam int PRE_C = 2;
    localparam int DLY_C = 10;
    localparam int GAP_C = 2;
    localparam int TMO_C = 50;

    // Load-to-load spacing in clock cycles.
    localparam int SP_FIRST = 2;
    localparam int SP_GAP   = 2 + 5 + GAP_C;
    localparam int SP_DLY   = 2 + 5 + DLY_C;

    typedef struct {
        bit wr;
        int idx;
        int sp;
    } exp_t;

    exp_t exp_q[$];

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    int last_evt    = 0;
    int nl          = 0;

    logic       clk      = 1'b0;
    logic       arstn    = 1'b0;
    logic       spur_en  = 1'b0;
    logic       drop_en  = 1'b0;
    logic [1:0] drop_idx = 2'd0;
    logic [1:0] start_v  = 2'b00;
    logic [1:0] ldone;
    logic [1:0] load_v;
    logic [1:0] write_v;
    logic [1:0] busy_v;
    logic [1:0] done_v;
    logic [1:0] err_v;
    logic [1:0] idx_v [2];
    logic [7:0] since [2];
    logic [1:0] drop_r;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    si5340_load_sequencer #(
        .NUM_ENTRIES(N_C), .PREAMBLE_LEN(PRE_C), .DELAY_CYCLES(DLY_C),
        .GAP_CYCLES(GAP_C), .TIMEOUT_CYCLES(TMO_C), .READBACK(1)
    ) u_dut (
        .clk_i(clk), .arstn_i(arstn), .start_i(start_v[0]), .loader_done_i(ldone[0]),
        .load_o(load_v[0]), .write_o(write_v[0]), .busy_o(busy_v[0]), .done_o(done_v[0]),
        .timeout_err_o(err_v[0]), .entry_idx_o(idx_v[0])
    );

    si5340_load_sequencer #(
        .NUM_ENTRIES(N_C), .PREAMBLE_LEN(PRE_C), .DELAY_CYCLES(DLY_C),
        .GAP_CYCLES(GAP_C), .TIMEOUT_CYCLES(TMO_C), .READBACK(0)
    ) u_dut_nr (
        .clk_i(clk), .arstn_i(arstn), .start_i(start_v[1]), .loader_done_i(ldone[1]),
        .load_o(load_v[1]), .write_o(write_v[1]), .busy_o(busy_v[1]), .done_o(done_v[1]),
        .timeout_err_o(err_v[1]), .entry_idx_o(idx_v[1])
    );

    // Loader model. since counts the cycles after a load strobe, starting at
    // 1, and saturates. The model raises done 5 cycles after the load
    // strobe, counting the strobe cycle as the first. While spur_en is set,
    // it also sends stray done pulses at times when the sequencer is not
    // waiting for one.
    always @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            for (int k = 0; k < 2; k++) since[k] <= 8'd0;
            drop_r <= 2'b00;
        end else begin
            for (int k = 0; k < 2; k++) begin
                if (load_v[k]) begin
                    since[k]  <= 8'd1;
                    drop_r[k] <= drop_en && write_v[k] && (idx_v[k] == drop_idx);
                end else if (since[k] != 8'd0 && since[k] != 8'hFF) begin
                    since[k] <= since[k] + 8'd1;
                end
            end
        end
    end

    assign ldone[0] = (since[0] == 8'd4 && !drop_r[0]) ||
                      (spur_en && (since[0] == 8'd5 || since[0] == 8'd7 || since[0] == 8'd12));
    assign ldone[1] = (since[1] == 8'd4 && !drop_r[1]) ||
                      (spur_en && (since[1] == 8'd5 || since[1] == 8'd7 || since[1] == 8'd12));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Queue the expected loads of one run: write pass, then an optional read
    // pass. Only the first nloads loads are queued.
    task automatic push_run(input bit rb, input int nloads);
        exp_t e;
        int   n;
        bit   pwr;
        int   pidx;
        n = 0; pwr = 1'b0; pidx = 0;
        for (int p = 0; p < 2; p++) begin
            if (p == 0 || rb) begin
                for (int i = 0; i < N_C; i++) begin
                    if (n < nloads) begin
                        e.wr  = (p == 0);
                        e.idx = i;
                        if (n == 0) e.sp = SP_FIRST;
                        else if (pwr && pidx == PRE_C - 1) e.sp = SP_DLY;
                        else e.sp = SP_GAP;
                        exp_q.push_back(e);
                    end
                    pwr  = (p == 0);
                    pidx = i;
                    n++;
                end
            end
        end
    endtask

    // Pulse start for one cycle, then check the state right after acceptance.
    task automatic launch(input int k);
        @(negedge clk);
        start_v[k] = 1'b1;
        last_evt   = cyc;
        @(negedge clk);
        start_v[k] = 1'b0;
        check("acc_busy", busy_v[k], 1);
        check("acc_idx", idx_v[k], 0);
        check("acc_write", write_v[k], 1);
        check("acc_err", err_v[k], 0);
    endtask

    // Watch one instance cycle by cycle and check each load strobe against
    // the scoreboard. Optional start pokes are sent mid-run. The task stops
    // on done, on an error (if stop_err is set) or after stop_loads loads.
    task automatic monitor(input int k, input int budget, input bit stop_err,
                           input int stop_loads, input int poke1, input int poke2,
                           output int nloads);
        exp_t e;
        bit   fin;
        fin    = 1'b0;
        nloads = 0;
        for (int c = 0; c < budget && !fin; c++) begin
            @(negedge clk);
            start_v[k] = (c == poke1 || c == poke2);
            if (load_v[k]) begin
                nloads++;
                check("load_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("load_write", write_v[k], e.wr);
                    check("load_idx", idx_v[k], e.idx);
                    check("load_spacing", cyc - last_evt, e.sp);
                end
                last_evt = cyc;
                if (stop_loads > 0 && nloads == stop_loads) fin = 1'b1;
            end
            if (done_v[k]) begin
                check("done_busy", busy_v[k], 0);
                check("done_q_empty", exp_q.size(), 0);
                fin = 1'b1;
            end
            if (stop_err && err_v[k]) fin = 1'b1;
        end
        start_v[k] = 1'b0;
        check("run_end", fin, 1);
    endtask

    initial begin
        // Reset with start held high: every output must read zero.
        start_v = 2'b01;
        repeat (3) @(negedge clk);
        check("rst_outs0", {load_v[0], write_v[0], busy_v[0], done_v[0], err_v[0], idx_v[0]}, 0);
        check("rst_outs1", {load_v[1], write_v[1], busy_v[1], done_v[1], err_v[1], idx_v[1]}, 0);

        // Release reset with start still high: a full write and read-back run.
        arstn    = 1'b1;
        last_evt = cyc;
        push_run(1'b1, 8);
        @(negedge clk);
        start_v[0] = 1'b0;
        check("rel_busy", busy_v[0], 1);
        monitor(0, 300, 1'b0, 0, -1, -1, nl);
        check("full_loads", nl, 8);
        check("full_last_idx", idx_v[0], N_C - 1);
        check("full_last_write", write_v[0], 0);
        @(negedge clk);
        check("done_one_cycle", done_v[0], 0);

        // Read-back disabled: write pass only.
        push_run(1'b0, 8);
        launch(1);
        monitor(1, 300, 1'b0, 0, -1, -1, nl);
        check("nr_loads", nl, 4);
        check("nr_write_held", write_v[1], 1);

        // Stray done pulses and start pulses mid-run must not change anything.
        spur_en = 1'b1;
        push_run(1'b1, 8);
        launch(0);
        monitor(0, 300, 1'b0, 0, 10, 30, nl);
        check("spur_loads", nl, 8);
        spur_en = 1'b0;

        // The loader never answers entry 2 of the write pass: expect a timeout.
        drop_en  = 1'b1;
        drop_idx = 2'd2;
        push_run(1'b1, 3);
        launch(0);
        monitor(0, 300, 1'b1, 0, -1, -1, nl);
        check("tmo_latency", cyc - last_evt, TMO_C);
        check("tmo_busy", busy_v[0], 0);
        check("tmo_no_done", done_v[0], 0);
        check("tmo_loads", nl, 3);
        repeat (5) @(negedge clk);
        check("tmo_sticky", err_v[0], 1);
        drop_en = 1'b0;
        launch(0);
        arstn = 1'b0;
        #1;
        check("tmo_rst_outs", {load_v[0], write_v[0], busy_v[0], done_v[0], err_v[0], idx_v[0]}, 0);
        exp_q.delete();
        @(negedge clk);
        arstn = 1'b1;

        // Reset asserted during the settle delay, then a clean restart.
        push_run(1'b1, 8);
        launch(0);
        monitor(0, 100, 1'b0, 2, -1, -1, nl);
        repeat (7) @(negedge clk);
        check("dly_busy", busy_v[0], 1);
        check("dly_idx", idx_v[0], 1);
        arstn = 1'b0;
        #1;
        check("dly_rst_outs", {load_v[0], write_v[0], busy_v[0], done_v[0], err_v[0], idx_v[0]}, 0);
        exp_q.delete();
        @(negedge clk);
        arstn = 1'b1;
        push_run(1'b1, 8);
        launch(0);
        monitor(0, 300, 1'b0, 0, -1, -1, nl);
        check("restart_loads", nl, 8);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
